// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one external memory port between IF and MEM stages
// Optional round-robin arbitration: define MEM_ARB_RR_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_re,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_busy,
  output logic                  if_done,
  output logic [DATA_W-1:0]     if_data,
  input  logic                  mem_re,
  input  logic                  mem_we,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W/8-1:0]   mem_wmask,
  output logic                  mem_busy,
  output logic                  mem_done,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  output logic [DATA_W/8-1:0]   ram_wmask,
  input  logic                  ram_ack,
  input  logic [DATA_W-1:0]     ram_rdata
);

  localparam int         MASK_W  = DATA_W / 8;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SERVE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              owner_mem_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;
  logic [DATA_W-1:0] if_data_q;
  logic [DATA_W-1:0] mem_rdata_q;

  logic mem_req;
  logic any_req;
  logic grant_mem;

  assign mem_req = mem_re | mem_we;
  assign any_req = mem_req | if_re;

`ifdef MEM_ARB_RR_EN
  // last_grant_q: 1 = MEM won the previous grant; reset points at IF
  logic last_grant_q;

  assign grant_mem = mem_req & (~if_re | ~last_grant_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b0;
    end else if (state_q == S_IDLE && any_req) begin
      last_grant_q <= grant_mem;
    end
  end
`else
  assign grant_mem = mem_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_SERVE;
      S_SERVE: if (ram_ack) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ram_req  = (state_q == S_SERVE);
    ram_we   = (state_q == S_SERVE) & we_q;
    if_busy  = (state_q != S_IDLE);
    mem_busy = (state_q != S_IDLE);
    if_done  = (state_q == S_DONE) & ~owner_mem_q;
    mem_done = (state_q == S_DONE) & owner_mem_q;
  end

  // Command latch and read-data capture; the mask is forced to 0 for reads
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_mem_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else if (state_q == S_IDLE && any_req) begin
      owner_mem_q <= grant_mem;
      if (grant_mem) begin
        we_q    <= mem_we;
        addr_q  <= mem_addr;
        wdata_q <= mem_we ? mem_wdata : '0;
        wmask_q <= mem_we ? mem_wmask : '0;
      end else begin
        we_q    <= 1'b0;
        addr_q  <= if_addr;
        wdata_q <= '0;
        wmask_q <= '0;
      end
    end else if (state_q == S_SERVE && ram_ack && !we_q) begin
      if (owner_mem_q) begin
        mem_rdata_q <= ram_rdata;
      end else begin
        if_data_q <= ram_rdata;
      end
    end
  end

  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_wmask = wmask_q;
  assign if_data   = if_data_q;
  assign mem_rdata = mem_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed + randomized transaction-level check of the arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_re = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_busy, if_done;
  logic [31:0] if_data;
  logic        mem_re = 1'b0, mem_we = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_wmask = '0;
  logic        mem_busy, mem_done;
  logic [31:0] mem_rdata;
  logic        ram_req, ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic [3:0]  ram_wmask;
  logic        ram_ack = 1'b0;
  logic [31:0] ram_rdata = '0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_re(if_re), .if_addr(if_addr), .if_busy(if_busy), .if_done(if_done), .if_data(if_data),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_busy(mem_busy), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wmask(ram_wmask), .ram_ack(ram_ack), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference state: the two data registers as seen by the stages, and who won last
  logic [31:0] m_if_data   = '0;
  logic [31:0] m_mem_rdata = '0;
  bit          m_last_mem  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req"},   {31'd0, ram_req},  32'd0);
    check({tag, "_done"},  {30'd0, if_done, mem_done}, 32'd0);
    check({tag, "_busy"},  {30'd0, if_busy, mem_busy}, 32'd0);
  endtask

  // One complete transaction from IDLE back to IDLE; lat = SERVE cycles before the ack
  task automatic txn(input bit ir, input bit mr, input bit mw,
                     input logic [31:0] ia, input logic [31:0] ma,
                     input logic [31:0] wd, input logic [3:0] wm,
                     input int lat, input logic [31:0] rd, output int done_cyc);
    bit          own_mem, is_wr;
    logic [31:0] ea;
    int          start_cyc;
`ifdef MEM_ARB_RR_EN
    own_mem = (mr | mw) && !(ir && m_last_mem);
`else
    own_mem = mr | mw;
`endif
    m_last_mem = own_mem;
    is_wr      = own_mem && mw;
    ea         = own_mem ? ma : ia;

    if_re = ir; if_addr = ia; mem_re = mr; mem_we = mw;
    mem_addr = ma; mem_wdata = wd; mem_wmask = wm; ram_ack = 1'b0;
    start_cyc = cyc;
    tick();
    check("serve_req",   {31'd0, ram_req}, 32'd1);
    check("serve_busy",  {30'd0, if_busy, mem_busy}, 32'd3);
    check("serve_we",    {31'd0, ram_we}, {31'd0, is_wr});
    check("serve_mask",  {28'd0, ram_wmask}, is_wr ? {28'd0, wm} : 32'd0);
    if (is_wr) check("serve_wdata", ram_wdata, wd);
    if_addr = $urandom; mem_addr = $urandom; mem_wdata = $urandom; mem_wmask = 4'($urandom);
    for (int i = 0; i < lat; i++) begin
      check("serve_addr", ram_addr, ea);
      tick();
      check("serve_hold", {31'd0, ram_req}, 32'd1);
    end
    check("serve_addr", ram_addr, ea);
    ram_ack = 1'b1; ram_rdata = rd;
    tick();
    ram_ack = 1'b0; ram_rdata = $urandom;
    if (!is_wr) begin
      if (own_mem) m_mem_rdata = rd;
      else         m_if_data   = rd;
    end
    done_cyc = cyc;
    check("done_if",    {31'd0, if_done},  {31'd0, !own_mem});
    check("done_mem",   {31'd0, mem_done}, {31'd0, own_mem});
    check("done_req",   {31'd0, ram_req}, 32'd0);
    check("done_busy",  {30'd0, if_busy, mem_busy}, 32'd3);
    check("done_lat",   done_cyc - start_cyc, 32'(2 + lat));
    check("if_data",    if_data,   m_if_data);
    check("mem_rdata",  mem_rdata, m_mem_rdata);
    if_re = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
    tick();
    check_quiet("idle");
  endtask

  int d0, d1;

  initial begin
    // Reset with a stale ack present
    ram_ack = 1'b1; if_re = 1'b1; mem_re = 1'b1;
    tick();
    check_quiet("rst1");
    tick();
    check_quiet("rst2");
    check("rst_addr",  ram_addr, 32'd0);
    check("rst_data",  if_data | mem_rdata | ram_wdata, 32'd0);
    if_re = 1'b0; mem_re = 1'b0;
    rst = 1'b0;
    tick();
    check_quiet("stale_ack");
    ram_ack = 1'b0;

    // IF read with 3-cycle ack latency
    txn(1, 0, 0, 32'h100, 32'h0, 32'h0, 4'h0, 3, 32'h0000_0013, d0);
    // Store acked in the first SERVE cycle; mem_rdata must stay 0
    txn(0, 0, 1, 32'h0, 32'h2004, 32'hDEAD_BEEF, 4'b0011, 0, 32'h5555_5555, d0);
    // Read+write together is a write
    txn(0, 1, 1, 32'h0, 32'h3000, 32'h1234_5678, 4'b1111, 1, 32'h7777_7777, d0);

    // Contention: MEM first, then IF, then four contended grants
    txn(1, 1, 0, 32'h200, 32'h400, 32'h0, 4'hF, 0, 32'hA5A5_0001, d0);
    txn(1, 0, 0, 32'h200, 32'h0,   32'h0, 4'h0, 0, 32'hA5A5_0002, d0);
    for (int k = 0; k < 4; k++)
      txn(1, 1, 0, 32'h300 + 32'(k), 32'h500 + 32'(k), 32'h0, 4'hF, 1, 32'hC0DE_0000 + 32'(k), d0);

    // Reset in the middle of SERVE, ack arrives the following cycle
    mem_re = 1'b1; mem_addr = 32'h600;
    tick();
    check("mid_serve_req", {31'd0, ram_req}, 32'd1);
    rst = 1'b1; mem_re = 1'b0;
    tick();
    m_if_data = '0; m_mem_rdata = '0; m_last_mem = 1'b0;
    check_quiet("mid_rst");
    check("mid_rst_if_data",   if_data,   m_if_data);
    check("mid_rst_mem_rdata", mem_rdata, m_mem_rdata);
    rst = 1'b0; ram_ack = 1'b1; ram_rdata = 32'hFFFF_FFFF;
    tick();
    ram_ack = 1'b0;
    check_quiet("post_rst_ack");
    check("post_rst_mem_rdata", mem_rdata, 32'd0);

    // Back-to-back IF reads with immediate acks: one done every 3 cycles
    txn(1, 0, 0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 32'h1111_0000, d0);
    txn(1, 0, 0, 32'h4, 32'h0, 32'h0, 4'h0, 0, 32'h2222_0004, d1);
    check("b2b_spacing", d1 - d0, 32'd3);

    // Randomized traffic against the model
    for (int n = 0; n < 30; n++) begin
      bit ir, mr, mw;
      ir = 1'($urandom); mr = 1'($urandom); mw = 1'($urandom);
      if (!(ir | mr | mw)) ir = 1'b1;
      txn(ir, mr, mw, $urandom, $urandom, $urandom, 4'($urandom),
          int'($urandom_range(0, 3)), $urandom, d0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
